// File: rtl/crypt_pkg.sv
// Shared types and bit-permutation helpers for the streaming encrypter and its decrypter.
// Stage data width is fixed by N_DEF; instantiating modules must keep N equal to it.
package crypt_pkg;

    localparam int unsigned N_DEF           = 8;
    localparam int unsigned BLOCK_BYTES_DEF = 32;

    typedef struct packed {
        logic [N_DEF-1:0] data;
        logic             valid;
        logic             last;
    } stage_t;

    function automatic logic [N_DEF-1:0] swap_halves(input logic [N_DEF-1:0] x);
        return {x[N_DEF/2-1:0], x[N_DEF-1:N_DEF/2]};
    endfunction

    function automatic logic [N_DEF-1:0] bit_reverse(input logic [N_DEF-1:0] x);
        logic [N_DEF-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_DEF; i++) begin
            r[i] = x[N_DEF-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_block_ctrl.sv
// Block framing: word position counter, per-block key register, key select and last flag.
module enc_block_ctrl
    import crypt_pkg::*;
#(
    parameter int unsigned N           = N_DEF,
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           accept_i,
    input  logic [N-1:0]                   key_i,
    output logic [N-1:0]                   key_sel_o,
    output logic                           last_o,
    output logic [$clog2(BLOCK_BYTES)-1:0] block_idx_o
);

    localparam int unsigned IW = $clog2(BLOCK_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  key_q, key_d;
    logic          first_word;

    assign first_word = (idx_q == '0);

    // The first word of a block must use the live key, not the stale register.
    assign key_sel_o   = first_word ? key_i : key_q;
    assign last_o      = (idx_q == LAST_IDX);
    assign block_idx_o = idx_q;

    always_comb begin
        idx_d = idx_q;
        key_d = key_q;
        if (accept_i) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
            if (first_word) begin
                key_d = key_i;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            key_q <= '0;
        end else begin
            idx_q <= idx_d;
            key_q <= key_d;
        end
    end

endmodule

// File: rtl/encryption_stream.sv
// Streaming byte encrypter: four-stage forward transform with block framing and a
// single global advance; stages hold together on output backpressure.
module encryption_stream
    import crypt_pkg::*;
#(
    parameter int unsigned N           = N_DEF,
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N-1:0]                   key,
    input  logic [N-1:0]                   data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N-1:0]                   e_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [$clog2(BLOCK_BYTES)-1:0] block_idx
);

    stage_t s1_q, s2_q, s3_q, s4_q;
    stage_t s1_d, s2_d, s3_d, s4_d;
    logic          adv;
    logic          accept;
    logic          blk_last;
    logic [N-1:0]  key_sel;

    assign adv      = !s4_q.valid | out_ready;
    assign accept   = in_valid & adv;
    assign in_ready = adv;

    enc_block_ctrl #(
        .N           (N),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .accept_i    (accept),
        .key_i       (key),
        .key_sel_o   (key_sel),
        .last_o      (blk_last),
        .block_idx_o (block_idx)
    );

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        s4_d = s4_q;
        if (adv) begin
            s1_d.data  = swap_halves(data ^ key_sel);
            s1_d.valid = accept;
            s1_d.last  = accept & blk_last;

            s2_d.data  = ~s1_q.data;
            s2_d.valid = s1_q.valid;
            s2_d.last  = s1_q.last;

            s3_d.data  = bit_reverse(s2_q.data);
            s3_d.valid = s2_q.valid;
            s3_d.last  = s2_q.last;

            s4_d.data  = swap_halves(s3_q.data);
            s4_d.valid = s3_q.valid;
            s4_d.last  = s3_q.last;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end

    assign e_data    = s4_q.data;
    assign out_valid = s4_q.valid;
    assign out_last  = s4_q.last;

endmodule

// File: tb/tb_encryption_stream.sv
// Directed self-checking bench for encryption_stream (N=8, BLOCK_BYTES=32).
module tb_encryption_stream;
    import crypt_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] key;
    logic [7:0] data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] e_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [4:0] block_idx;

    int checks = 0;
    int errors = 0;

    encryption_stream #(
        .N           (8),
        .BLOCK_BYTES (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .data      (data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_data    (e_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .block_idx (block_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Whole transform collapses to ~rev(d ^ k) for even N.
    function automatic logic [7:0] enc_ref(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] x, r;
        x = d ^ k;
        for (int i = 0; i < 8; i++) r[i] = ~x[7-i];
        return r;
    endfunction

    function automatic logic [7:0] dec_ref(input logic [7:0] e, input logic [7:0] k);
        return swap_halves(~bit_reverse(swap_halves(e))) ^ k;
    endfunction

    task automatic tick(input logic v, input logic [7:0] d, input logic [7:0] k, input logic r,
                        output logic ov, output logic [7:0] od, output logic ol, output logic ir);
        @(negedge clock);
        ov = out_valid;
        od = e_data;
        ol = out_last;
        in_valid  = v;
        data      = d;
        key       = k;
        out_ready = r;
        #1;
        ir = in_ready;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key = '0; data = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_flags valid=%b last=%b exp 0 0", out_valid, out_last);
        end
        checks++;
        if (e_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", e_data); end
        checks++;
        if (block_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", block_idx); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        logic ov, ol, ir;
        logic [7:0] od;
        do_reset();
        tick(1'b1, 8'h3C, 8'h5A, 1'b1, ov, od, ol, ir);
        checks++;
        if (ir !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", ir); end
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 8'h00, 8'h00, 1'b1, ov, od, ol, ir);
            checks++;
            if (ov !== (c == 4)) begin
                errors++; $display("FAIL single_latency cycle %0d valid=%b exp %b", c, ov, (c == 4));
            end
        end
        checks++;
        if (od !== 8'h99 || ol !== 1'b0) begin
            errors++; $display("FAIL single_data got %02h last %b exp 99 last 0", od, ol);
        end
        checks++;
        if (block_idx !== 5'd1) begin errors++; $display("FAIL single_idx got %0d exp 1", block_idx); end
    endtask

    task automatic test_single_zero_key();
        logic ov, ol, ir;
        logic [7:0] od;
        do_reset();
        tick(1'b1, 8'h01, 8'h00, 1'b1, ov, od, ol, ir);
        for (int c = 1; c <= 4; c++) tick(1'b0, 8'h00, 8'h00, 1'b1, ov, od, ol, ir);
        checks++;
        if (ov !== 1'b1 || od !== 8'h7F) begin
            errors++; $display("FAIL zero_key got valid %b data %02h exp 1 7F", ov, od);
        end
        checks++;
        if (dec_ref(od, 8'h00) !== 8'h01) begin
            errors++; $display("FAIL zero_key_decrypt got %02h exp 01", dec_ref(od, 8'h00));
        end
    endtask

    task automatic test_key_hold();
        logic ov, ol, ir;
        logic [7:0] od, k;
        int sent = 0, got = 0;
        do_reset();
        for (int cyc = 0; cyc < 60 && got < 32; cyc++) begin
            k = (sent == 0) ? 8'hA5 : 8'($urandom);
            tick(sent < 32, 8'(sent), k, 1'b1, ov, od, ol, ir);
            if (ov) begin
                checks++;
                if (od !== enc_ref(8'(got), 8'hA5) || ol !== (got == 31)) begin
                    errors++; $display("FAIL key_hold word %0d got %02h last %b exp %02h last %b",
                                       got, od, ol, enc_ref(8'(got), 8'hA5), (got == 31));
                end
                got++;
            end
            if (sent < 32 && ir) sent++;
        end
        checks++;
        if (got !== 32) begin errors++; $display("FAIL key_hold_count got %0d exp 32", got); end
        checks++;
        if (block_idx !== 5'd0) begin errors++; $display("FAIL key_hold_wrap got %0d exp 0", block_idx); end
    endtask

    task automatic test_backpressure();
        logic ov, ol, ir, rdy, hold_l;
        logic [7:0] od, hold_d;
        int sent = 0, got = 0;
        hold_d = '0; hold_l = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            rdy = !(cyc >= 6 && cyc <= 8);
            tick(sent < 10, 8'h40 + 8'(sent), 8'h3C, rdy, ov, od, ol, ir);
            if (!rdy) begin
                checks++;
                if (ov !== 1'b1 || ir !== 1'b0) begin
                    errors++; $display("FAIL bp_stall cycle %0d valid %b ready %b exp 1 0", cyc, ov, ir);
                end
                if (cyc == 6) begin
                    hold_d = od; hold_l = ol;
                end else begin
                    checks++;
                    if (od !== hold_d || ol !== hold_l) begin
                        errors++; $display("FAIL bp_hold cycle %0d got %02h/%b exp %02h/%b",
                                           cyc, od, ol, hold_d, hold_l);
                    end
                end
            end
            if (ov && rdy) begin
                checks++;
                if (od !== enc_ref(8'h40 + 8'(got), 8'h3C) || ol !== 1'b0) begin
                    errors++; $display("FAIL bp_order word %0d got %02h exp %02h",
                                       got, od, enc_ref(8'h40 + 8'(got), 8'h3C));
                end
                got++;
            end
            if (sent < 10 && ir) sent++;
        end
        checks++;
        if (got !== 10) begin errors++; $display("FAIL bp_count got %0d exp 10", got); end
        repeat (5) tick(1'b0, 8'h00, 8'h00, 1'b1, ov, od, ol, ir);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL bp_extra got valid %b exp 0", ov); end
        checks++;
        if (block_idx !== 5'd10) begin errors++; $display("FAIL bp_idx got %0d exp 10", block_idx); end
    endtask

    task automatic test_block_boundary();
        logic ov, ol, ir;
        logic [7:0] od, k, ek;
        int sent = 0, got = 0, lasts = 0;
        do_reset();
        for (int cyc = 0; cyc < 90 && got < 64; cyc++) begin
            k = (sent == 0) ? 8'h11 : (sent == 32) ? 8'hEE : 8'h55;
            tick(sent < 64, 8'(sent), k, 1'b1, ov, od, ol, ir);
            if (ov) begin
                ek = (got < 32) ? 8'h11 : 8'hEE;
                checks++;
                if (od !== enc_ref(8'(got), ek) || ol !== (got == 31 || got == 63)) begin
                    errors++; $display("FAIL boundary word %0d got %02h last %b exp %02h",
                                       got, od, ol, enc_ref(8'(got), ek));
                end
                if (ol) lasts++;
                got++;
            end
            if (sent < 64 && ir) sent++;
        end
        checks++;
        if (got !== 64 || lasts !== 2) begin
            errors++; $display("FAIL boundary_count got %0d words %0d lasts exp 64 2", got, lasts);
        end
    endtask

    task automatic test_reset_mid();
        logic ov, ol, ir;
        logic [7:0] od;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(c < 7, 8'h20 + 8'(c), (c == 0) ? 8'h77 : 8'h00, 1'b1, ov, od, ol, ir);
        end
        @(negedge clock);
        checks++;
        if (block_idx !== 5'd7 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre idx %0d valid %b exp 7 1", block_idx, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || block_idx !== 5'd0 || e_data !== 8'h00) begin
            errors++; $display("FAIL mid_async valid %b idx %0d data %02h exp 0 0 00",
                               out_valid, block_idx, e_data);
        end
        @(negedge clock);
        reset = 1'b0;
        tick(1'b1, 8'h12, 8'h3A, 1'b1, ov, od, ol, ir);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++; $display("FAIL mid_restart valid %b ready %b exp 0 1", ov, ir);
        end
        for (int c = 1; c <= 4; c++) begin
            tick(1'b0, 8'h00, 8'h00, 1'b1, ov, od, ol, ir);
            checks++;
            if (ov !== (c == 4)) begin
                errors++; $display("FAIL mid_latency cycle %0d valid %b exp %b", c, ov, (c == 4));
            end
        end
        checks++;
        if (od !== 8'hEB || block_idx !== 5'd1) begin
            errors++; $display("FAIL mid_data got %02h idx %0d exp EB 1", od, block_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_single_zero_key();
        test_key_hold();
        test_backpressure();
        test_block_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
